hilo_unit: RTL and testbench

HI/LO register unit and multiply sequencer for the multi-cycle MIPS datapath. It sits directly downstream of the combinational 32x32 signed multiplier (`mult`) and owns the architectural HI and LO registers. It executes MULT, MULTU, MTHI, MTLO, MFHI and MFLO under a start/busy/done handshake with the control FSM. For multiplies it holds the multiplier operands stable for a fixed settle window, applies unsigned correction for MULTU, and commits the 64-bit result to HI/LO.

---
 rtl/hilo_pkg.sv | 25 ++
 rtl/multu_fix.sv | 28 ++
 rtl/hilo_unit.sv | 138 +++++++++++++
 tb/tb_hilo_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// ============================================================================
// hilo_pkg : shared op encodings and state type for the HI/LO unit
// Revision : 1.0
// ============================================================================
`default_nettype none

package hilo_pkg;

    localparam logic [2:0] HILO_NOP   = 3'd0;
    localparam logic [2:0] HILO_MULT  = 3'd1;
    localparam logic [2:0] HILO_MULTU = 3'd2;
    localparam logic [2:0] HILO_MTHI  = 3'd3;
    localparam logic [2:0] HILO_MTLO  = 3'd4;
    localparam logic [2:0] HILO_MFHI  = 3'd5;
    localparam logic [2:0] HILO_MFLO  = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/multu_fix.sv
// ============================================================================
// multu_fix : converts a signed 32x32 product into the unsigned product
// Revision  : 1.0
// ============================================================================
`default_nettype none

module multu_fix (
    input  logic [63:0] mult_z_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        signed_i,
    output logic [63:0] prod_o
);

    logic [31:0] w_add_a;
    logic [31:0] w_add_b;
    logic [31:0] w_hi_fix;

    // A negative-read operand lost 2^32 of weight; add the other operand back
    // into the upper word (the lower word is identical for both signednesses).
    assign w_add_a  = (!signed_i && a_i[31]) ? b_i : 32'd0;
    assign w_add_b  = (!signed_i && b_i[31]) ? a_i : 32'd0;
    assign w_hi_fix = mult_z_i[63:32] + w_add_a + w_add_b;
    assign prod_o   = {w_hi_fix, mult_z_i[31:0]};

endmodule

`default_nettype wire

// File: rtl/hilo_unit.sv
// ============================================================================
// hilo_unit : HI/LO registers and multiply sequencer for the MIPS datapath
// Revision  : 1.0
// ============================================================================
`default_nettype none

module hilo_unit
    import hilo_pkg::*;
#(
    parameter int MULT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [63:0] mult_z,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    output logic        mult_ena,
    output logic        mult_reset,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam logic [3:0] CNT_INIT = 4'(MULT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        signed_q, signed_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] rd_q, rd_d;
    logic [63:0] w_prod;

    multu_fix u_multu_fix (
        .mult_z_i (mult_z),
        .a_i      (a_q),
        .b_i      (b_q),
        .signed_i (signed_q),
        .prod_o   (w_prod)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            signed_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            rd_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            rd_q     <= rd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        rd_d     = rd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        HILO_MULT, HILO_MULTU: begin
                            a_d      = rs_data;
                            b_d      = rt_data;
                            signed_d = (op == HILO_MULT);
                            cnt_d    = CNT_INIT;
                            state_d  = CALC;
                        end
                        HILO_MTHI: begin
                            hi_d    = rs_data;
                            state_d = DONE;
                        end
                        HILO_MTLO: begin
                            lo_d    = rs_data;
                            state_d = DONE;
                        end
                        HILO_MFHI: begin
                            rd_d    = hi_q;
                            state_d = DONE;
                        end
                        HILO_MFLO: begin
                            rd_d    = lo_q;
                            state_d = DONE;
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                // Product is sampled only here, after the settle window.
                if (cnt_q == 4'd0) begin
                    {hi_d, lo_d} = w_prod;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mult_a     = a_q;
    assign mult_b     = b_q;
    assign mult_ena   = (state_q == CALC);
    assign mult_reset = reset;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign rd_data    = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_hilo_unit.sv
// ============================================================================
// tb_hilo_unit : directed self-checking bench for hilo_unit
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_hilo_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [63:0] mult_z;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic        mult_ena;
    logic        mult_reset;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int n_cmp = 0;
    int n_err = 0;
    int done_total = 0;

    hilo_unit #(.MULT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .mult_z     (mult_z),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_ena   (mult_ena),
        .mult_reset (mult_reset),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .rd_data    (rd_data)
    );

    // Behavioural stand-in for the external signed multiplier.
    logic signed [63:0] sa, sb;
    assign sa     = {{32{mult_a[31]}}, mult_a};
    assign sb     = {{32{mult_b[31]}}, mult_b};
    assign mult_z = sa * sb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_total++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt);
        start   = 1'b1;
        op      = o;
        rs_data = rs;
        rt_data = rt;
        tick();
        start   = 1'b0;
    endtask

    // Called right after issue(); counts busy cycles from E0 and where done shows.
    task automatic run_idle(output int busy_cyc, output int done_cnt, output int done_at);
        busy_cyc = 0;
        done_cnt = 0;
        done_at  = 0;
        while (busy && busy_cyc < 20) begin
            busy_cyc++;
            if (done) begin
                done_cnt++;
                done_at = busy_cyc;
            end
            tick();
        end
    endtask

    int bc, dc, da, d0;

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        op      = 3'd0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_rd", 64'(rd_data), 64'd0);
        chk("rst_ena", 64'(mult_ena), 64'd0);
        chk("rst_mreset", 64'(mult_reset), 64'd1);
        reset = 1'b0;
        tick();
        chk("mreset_low", 64'(mult_reset), 64'd0);

        // Signed multiply
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_ena", 64'(mult_ena), 64'd1);
        chk("mult_a", 64'(mult_a), 64'hFFFF_FFFE);
        chk("mult_b", 64'(mult_b), 64'd3);
        run_idle(bc, dc, da);
        chk("mult_busy_cycles", 64'(bc), 64'd5);
        chk("mult_done_cnt", 64'(dc), 64'd1);
        chk("mult_done_at", 64'(da), 64'd5);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFFA);

        // Unsigned multiplies
        issue(3'd2, 32'hFFFF_FFFE, 32'd3);
        run_idle(bc, dc, da);
        chk("multu_hi", 64'(hi), 64'h0000_0002);
        chk("multu_lo", 64'(lo), 64'hFFFF_FFFA);
        chk("multu_done_cnt", 64'(dc), 64'd1);
        issue(3'd2, 32'h8000_0000, 32'h8000_0000);
        run_idle(bc, dc, da);
        chk("multu_big_hi", 64'(hi), 64'h4000_0000);
        chk("multu_big_lo", 64'(lo), 64'd0);

        // Moves
        issue(3'd3, 32'h1234_5678, 32'd0);
        chk("mthi_hi", 64'(hi), 64'h1234_5678);
        run_idle(bc, dc, da);
        chk("mthi_busy_cycles", 64'(bc), 64'd1);
        chk("mthi_done_cnt", 64'(dc), 64'd1);
        issue(3'd5, 32'd0, 32'd0);
        chk("mfhi_rd", 64'(rd_data), 64'h1234_5678);
        run_idle(bc, dc, da);
        issue(3'd4, 32'hCAFE_F00D, 32'd0);
        run_idle(bc, dc, da);
        issue(3'd6, 32'd0, 32'd0);
        chk("mflo_rd", 64'(rd_data), 64'hCAFE_F00D);
        run_idle(bc, dc, da);
        chk("mflo_hi_kept", 64'(hi), 64'h1234_5678);

        // Start during CALC is dropped
        d0 = done_total;
        issue(3'd1, 32'd7, 32'd9);
        start   = 1'b1;
        op      = 3'd4;
        rs_data = 32'h0000_DEAD;
        tick();
        tick();
        chk("calc_a_held", 64'(mult_a), 64'd7);
        start = 1'b0;
        run_idle(bc, dc, da);
        chk("drop_lo", 64'(lo), 64'h0000_003F);
        chk("drop_hi", 64'(hi), 64'd0);
        chk("drop_done_cnt", 64'(done_total - d0), 64'd1);

        // Reset in the middle of CALC
        d0 = done_total;
        issue(3'd1, 32'd5, 32'd5);
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_ena", 64'(mult_ena), 64'd0);
        chk("midrst_rd", 64'(rd_data), 64'd0);
        reset = 1'b0;
        repeat (6) tick();
        chk("midrst_no_done", 64'(done_total - d0), 64'd0);
        chk("midrst_lo_after", 64'(lo), 64'd0);

        // Reserved op and NOP are no-ops
        issue(3'd3, 32'hA5A5_A5A5, 32'd0);
        run_idle(bc, dc, da);
        issue(3'd4, 32'h5A5A_5A5A, 32'd0);
        run_idle(bc, dc, da);
        issue(3'd5, 32'd0, 32'd0);
        run_idle(bc, dc, da);
        d0 = done_total;
        issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("op7_busy", 64'(busy), 64'd0);
        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("nop_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        chk("op7_no_done", 64'(done_total - d0), 64'd0);
        chk("op7_hi", 64'(hi), 64'hA5A5_A5A5);
        chk("op7_lo", 64'(lo), 64'h5A5A_5A5A);
        chk("op7_rd", 64'(rd_data), 64'hA5A5_A5A5);

        // Start during DONE is ignored
        issue(3'd3, 32'h1111_1111, 32'd0);
        start   = 1'b1;
        op      = 3'd4;
        rs_data = 32'h2222_2222;
        tick();
        start = 1'b0;
        run_idle(bc, dc, da);
        chk("done_ign_hi", 64'(hi), 64'h1111_1111);
        chk("done_ign_lo", 64'(lo), 64'h5A5A_5A5A);
        chk("done_ign_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
